// File: rtl/div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per clock. Divide-by-zero and signed overflow
// complete in one cycle. The destination register address travels with the result.
module div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_waddr_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      reg_waddr_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [4:0]        wout_q, wout_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;

    logic              is_signed, dvd_neg, dvs_neg, div0, ovf, ge;
    logic [XLEN-1:0]   dvd_abs, dvs_abs, rem_nx, quot_nx, q_fix, r_fix;
    logic [XLEN:0]     rem_sh, diff;

    // Operand conditioning and one restoring step
    always_comb begin
        is_signed = ~op_i[0];
        dvd_neg   = is_signed & dividend_i[XLEN-1];
        dvs_neg   = is_signed & divisor_i[XLEN-1];
        dvd_abs   = dvd_neg ? -dividend_i : dividend_i;
        dvs_abs   = dvs_neg ? -divisor_i  : divisor_i;
        div0      = (divisor_i == '0);
        ovf       = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (divisor_i == '1);
        // Shifted partial remainder keeps its carry bit so divisors with the
        // MSB set compare correctly.
        rem_sh    = {rem_q, dvd_q[XLEN-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        ge        = ~diff[XLEN];
        rem_nx    = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_nx   = {quot_q[XLEN-2:0], ge};
        q_fix     = negq_q ? -quot_nx : quot_nx;
        r_fix     = negr_q ? -rem_nx  : rem_nx;
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        waddr_d = waddr_q;
        wout_d  = wout_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    op_d    = op_i;
                    waddr_d = reg_waddr_i;
                    negq_d  = dvd_neg ^ dvs_neg;
                    negr_d  = dvd_neg;
                    dvd_d   = dvd_abs;
                    dvs_d   = dvs_abs;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = '0;
                    if (div0) begin
                        res_d   = op_i[1] ? dividend_i : '1;
                        wout_d  = reg_waddr_i;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        wout_d  = reg_waddr_i;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    res_d   = op_q[1] ? r_fix : q_fix;
                    wout_d  = waddr_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            waddr_q <= '0;
            wout_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            waddr_q <= waddr_d;
            wout_q  <= wout_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    // Status and result outputs
    always_comb begin
        busy_o      = (state_q == CALC);
        ready_o     = (state_q == DONE);
        result_o    = res_q;
        reg_waddr_o = wout_q;
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver pushes model results, the monitor checks on ready_o.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        busy_o, ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    div #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .reg_waddr_i(reg_waddr_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .reg_waddr_o(reg_waddr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        int unsigned lat;
        int unsigned busy;
        int unsigned cyc_s;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned bcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: RV32M results from plain arithmetic
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] wa);
        exp_t e;
        logic [31:0] q, r;
        e.wa = wa;
        e.lat = 1;
        e.busy = 0;
        e.cyc_s = 0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            if (!op[0]) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            e.lat = 33;
            e.busy = 32;
        end
        e.res = op[1] ? r : q;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa);
        exp_t e;
        e = model(op, a, b, wa);
        e.cyc_s = cyc;
        sb.push_back(e);
        start_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        reg_waddr_i = wa;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("completion_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a result is presented
    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
        end else begin
            if (busy_o) bcnt++;
            if (ready_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result_o, e.res);
                    chk("waddr", 32'(reg_waddr_o), 32'(e.wa));
                    chk("latency", cyc - e.cyc_s, e.lat);
                    chk("busy_cycles", bcnt, e.busy);
                    chk("busy_in_done", 32'(busy_o), 32'd0);
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned, signed and special cases
        issue(2'b01, 32'd100, 32'd7, 5'd3);            wait_done();
        issue(2'b11, 32'd100, 32'd7, 5'd4);            wait_done();
        issue(2'b00, -32'sd7, 32'd2, 5'd5);            wait_done();
        issue(2'b10, -32'sd7, 32'd2, 5'd6);            wait_done();
        issue(2'b00, 32'd7, -32'sd2, 5'd7);            wait_done();
        issue(2'b10, 32'd7, -32'sd2, 5'd8);            wait_done();
        issue(2'b01, 32'd5, 32'd0, 5'd9);              wait_done();
        issue(2'b11, 32'd5, 32'd0, 5'd10);             wait_done();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11); wait_done();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12); wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13); wait_done();

        // start_i during CALC must be ignored
        issue(2'b01, 32'd100, 32'd7, 5'd14);
        repeat (9) @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; dividend_i = 32'd55; divisor_i = 32'd3; reg_waddr_i = 5'd30;
        @(negedge clk);
        start_i = 1'b0;
        wait_done();

        // Reset mid-operation: no result may appear
        issue(2'b01, 32'd100, 32'd7, 5'd15);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("postrst_result", result_o, 32'd0);
        chk("postrst_waddr", 32'(reg_waddr_o), 32'd0);
        issue(2'b01, 32'd9, 32'd3, 5'd16);             wait_done();

        // Back-to-back: second start in the DONE cycle of the first
        issue(2'b01, 32'd100, 32'd7, 5'd17);
        repeat (32) @(negedge clk);
        issue(2'b11, 32'd9, 32'd4, 5'd18);
        wait_done();

        // Randomised operations, some back-to-back
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = rb >> $urandom_range(1, 31);
                3: ra = ra >> $urandom_range(1, 31);
                default: ;
            endcase
            issue(rop, ra, rb, 5'($urandom));
            if (i % 5 == 4) begin
                while (!ready_o) @(negedge clk);
                issue(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 1000), 5'($urandom));
            end
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1);
    end

endmodule
